// File: rtl/dma_pkg.sv
// ---------------------------------------------------------------------------
// dma_pkg
// Shared types and helpers for the 2D DMA read burst generator:
//   - state_t            : burst generator FSM states
//   - LEN_W / BEATS_W    : AXI ARLEN width and beat-count width (up to 256)
//   - bytes_of / off_w   : beat size in bytes and its log2, from a data width
//   - beats_to_boundary(): beats left before the next BOUNDARY-aligned address
// ---------------------------------------------------------------------------
package dma_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_ISSUE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int unsigned LEN_W   = 8;
    localparam int unsigned BEATS_W = LEN_W + 1;

    function automatic int unsigned bytes_of(input int unsigned data_w);
        return data_w / 8;
    endfunction

    function automatic int unsigned off_w(input int unsigned data_w);
        return $clog2(data_w / 8);
    endfunction

    // Boundary is a power of two no larger than 2^31, so the low 32 address
    // bits are enough to find the distance to the next boundary.
    function automatic logic [31:0] beats_to_boundary(input logic [31:0] addr_lo,
                                                      input int unsigned boundary,
                                                      input int unsigned offset_w);
        logic [31:0] offset;
        offset = addr_lo & (boundary - 32'd1);
        return (boundary - offset) >> offset_w;
    endfunction

endpackage

// File: rtl/dma_burst_len_calc.sv
// ---------------------------------------------------------------------------
// dma_burst_len_calc
// Combinational burst length for one row group: the minimum of the beats
// remaining in the row, MAX_BURST_LEN, and the beats each active lane can
// still issue before crossing a BOUNDARY-byte address.
// Ports:
//   lane_addr  in  LINES*ADDR_W  current byte address per lane
//   lane_mask  in  LINES         1 = lane is active and constrains the burst
//   rem_beats  in  ADDR_W+1      beats still to issue in this row (>= 1)
//   beats      out BEATS_W       beats for the next burst (1..MAX_BURST_LEN)
// ---------------------------------------------------------------------------
module dma_burst_len_calc
    import dma_pkg::*;
#(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned LINES         = 2,
    parameter int unsigned MAX_BURST_LEN = 16,
    parameter int unsigned BOUNDARY      = 4096,
    parameter int unsigned OFF_W         = 3
) (
    input  logic [LINES*ADDR_W-1:0] lane_addr,
    input  logic [LINES-1:0]        lane_mask,
    input  logic [ADDR_W:0]         rem_beats,
    output logic [BEATS_W-1:0]      beats
);

    localparam logic [ADDR_W:0] MAX_EXT = (ADDR_W+1)'(MAX_BURST_LEN);

    logic [31:0] cand;
    logic [31:0] to_bnd;

    always_comb begin
        cand   = 32'(MAX_BURST_LEN);
        to_bnd = '0;
        if (rem_beats < MAX_EXT) begin
            cand = 32'(rem_beats);
        end
        for (int j = 0; j < int'(LINES); j++) begin
            to_bnd = beats_to_boundary(32'(lane_addr[j*ADDR_W +: ADDR_W]), BOUNDARY, OFF_W);
            if (lane_mask[j] && (to_bnd < cand)) begin
                cand = to_bnd;
            end
        end
        beats = BEATS_W'(cand);
    end

endmodule

// File: rtl/dma_2d_read_burst_gen.sv
// ---------------------------------------------------------------------------
// dma_2d_read_burst_gen
// Walks a frame of (vsize+1) lines x (hsize+1) beats, LINES lines per row
// group, and issues one burst descriptor per step with a length shared by
// all lanes. Bursts are split at MAX_BURST_LEN and wherever any active lane
// would cross a BOUNDARY-byte address. Lanes past the last line of a short
// final group are masked and drive address 0.
// Ports:
//   clk_i, rst_ni     clock (rising edge), asynchronous active-low reset
//   base_addr_i       byte address of line 0, column 0 (beat aligned)
//   stride_i          byte distance between consecutive lines (beat aligned)
//   vsize_i, hsize_i  lines-1 and beats-per-line-1
//   start_i           start pulse, sampled only when idle
//   abort_i           cancel the running frame
//   ready_i           downstream accepts the current descriptor
//   valid_o           descriptor valid
//   addr_o            lane j byte address at [j*ADDR_W +: ADDR_W]
//   lane_mask_o       1 = lane j carries a real line
//   len_o             beats-1, common to all lanes
//   busy_o            frame in progress
//   done_o            one-cycle pulse after the last burst handshake
// ---------------------------------------------------------------------------
module dma_2d_read_burst_gen
    import dma_pkg::*;
#(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned DATA_W        = 64,
    parameter int unsigned MAX_BURST_LEN = 16,
    parameter int unsigned LINES         = 2,
    parameter int unsigned BOUNDARY      = 4096
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [ADDR_W-1:0]       base_addr_i,
    input  logic [ADDR_W-1:0]       stride_i,
    input  logic [ADDR_W-1:0]       vsize_i,
    input  logic [ADDR_W-1:0]       hsize_i,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic                    ready_i,
    output logic                    valid_o,
    output logic [LINES*ADDR_W-1:0] addr_o,
    output logic [LINES-1:0]        lane_mask_o,
    output logic [LEN_W-1:0]        len_o,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam int unsigned     BYTES      = bytes_of(DATA_W);
    localparam int unsigned     OFF_W      = off_w(DATA_W);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES - 1);
    localparam logic [ADDR_W:0]   LINES_EXT  = (ADDR_W+1)'(LINES);

    state_t                    state_q;
    logic [ADDR_W-1:0]         row_addr_q;
    logic [ADDR_W-1:0]         stride_q;
    logic [ADDR_W-1:0]         col_off_q;    // column offset in bytes
    logic [ADDR_W:0]           row_beats_q;  // hsize+1, kept wide so all-ones is legal
    logic [ADDR_W:0]           rem_q;
    logic [ADDR_W:0]           lines_left_q;
    logic [BEATS_W-1:0]        beats_q;

    logic [LINES*ADDR_W-1:0]   lane_addr_c;
    logic [LINES*ADDR_W-1:0]   lane_addr_masked_c;
    logic [LINES-1:0]          lane_mask_c;
    logic [BEATS_W-1:0]        beats_c;
    logic                      row_last_c;
    logic                      group_last_c;

    for (genvar j = 0; j < LINES; j++) begin : g_lane
        assign lane_addr_c[j*ADDR_W +: ADDR_W] = row_addr_q + stride_q * ADDR_W'(j) + col_off_q;
        assign lane_mask_c[j] = lines_left_q > (ADDR_W+1)'(j);
        assign lane_addr_masked_c[j*ADDR_W +: ADDR_W] =
            lane_mask_c[j] ? lane_addr_c[j*ADDR_W +: ADDR_W] : '0;
    end

    dma_burst_len_calc #(
        .ADDR_W        (ADDR_W),
        .LINES         (LINES),
        .MAX_BURST_LEN (MAX_BURST_LEN),
        .BOUNDARY      (BOUNDARY),
        .OFF_W         (OFF_W)
    ) u_len_calc (
        .lane_addr (lane_addr_c),
        .lane_mask (lane_mask_c),
        .rem_beats (rem_q),
        .beats     (beats_c)
    );

    assign row_last_c   = (rem_q == (ADDR_W+1)'(beats_q));
    assign group_last_c = (lines_left_q <= LINES_EXT);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            row_addr_q   <= '0;
            stride_q     <= '0;
            col_off_q    <= '0;
            row_beats_q  <= '0;
            rem_q        <= '0;
            lines_left_q <= '0;
            beats_q      <= '0;
            valid_o      <= 1'b0;
            addr_o       <= '0;
            lane_mask_o  <= '0;
            len_o        <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
        end else if (abort_i && (state_q != S_IDLE)) begin
            // Abort takes priority over a handshake in the same cycle.
            state_q <= S_IDLE;
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        row_addr_q   <= base_addr_i & ALIGN_MASK;
                        stride_q     <= stride_i & ALIGN_MASK;
                        col_off_q    <= '0;
                        row_beats_q  <= {1'b0, hsize_i} + 1'b1;
                        rem_q        <= {1'b0, hsize_i} + 1'b1;
                        lines_left_q <= {1'b0, vsize_i} + 1'b1;
                        busy_o       <= 1'b1;
                        state_q      <= S_CALC;
                    end
                end
                S_CALC: begin
                    addr_o      <= lane_addr_masked_c;
                    lane_mask_o <= lane_mask_c;
                    len_o       <= LEN_W'(beats_c - BEATS_W'(1));
                    beats_q     <= beats_c;
                    valid_o     <= 1'b1;
                    state_q     <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        if (!row_last_c) begin
                            col_off_q <= col_off_q + (ADDR_W'(beats_q) << OFF_W);
                            rem_q     <= rem_q - (ADDR_W+1)'(beats_q);
                            state_q   <= S_CALC;
                        end else if (group_last_c) begin
                            rem_q        <= '0;
                            lines_left_q <= '0;
                            done_o       <= 1'b1;
                            state_q      <= S_DONE;
                        end else begin
                            lines_left_q <= lines_left_q - LINES_EXT;
                            row_addr_q   <= row_addr_q + stride_q * ADDR_W'(LINES);
                            col_off_q    <= '0;
                            rem_q        <= row_beats_q;
                            state_q      <= S_CALC;
                        end
                    end
                end
                S_DONE: begin
                    done_o  <= 1'b0;
                    busy_o  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_2d_read_burst_gen.sv
// ---------------------------------------------------------------------------
// tb_dma_2d_read_burst_gen
// Drives directed and random frames into dma_2d_read_burst_gen (LINES=2,
// 64-bit beats, 16-beat bursts, 4 KB boundary) and compares every burst
// descriptor with a list computed from the frame geometry.
// ---------------------------------------------------------------------------
module tb_dma_2d_read_burst_gen;

    localparam int LINES = 2;
    localparam int MAXB  = 16;
    localparam int BYTES = 8;
    localparam int BOUND = 4096;

    typedef struct packed {
        logic [31:0] a0;
        logic [31:0] a1;
        logic [1:0]  m;
        logic [7:0]  len;
    } burst_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] base, stride, vsize, hsize;
    logic        start, abort, ready;
    logic        valid;
    logic [63:0] addr;
    logic [1:0]  mask;
    logic [7:0]  len;
    logic        busy, done;

    int     n_checks = 0;
    int     n_errors = 0;
    int     done_cnt = 0;
    burst_t exp_q[$];
    burst_t obs_q[$];

    dma_2d_read_burst_gen dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .base_addr_i (base),
        .stride_i    (stride),
        .vsize_i     (vsize),
        .hsize_i     (hsize),
        .start_i     (start),
        .abort_i     (abort),
        .ready_i     (ready),
        .valid_o     (valid),
        .addr_o      (addr),
        .lane_mask_o (mask),
        .len_o       (len),
        .busy_o      (busy),
        .done_o      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected bursts from the frame geometry: each group of LINES lines is
    // walked column by column, each step limited by the remaining beats,
    // the maximum burst and the distance of every real line to a 4 KB edge.
    function automatic void build(input logic [31:0] b, input logic [31:0] s,
                                  input logic [31:0] v, input logic [31:0] h);
        longint      lines, row_beats, col, nb, bb;
        logic [31:0] a, bm, sm, rem;
        burst_t      e;
        lines     = longint'({32'd0, v}) + 1;
        row_beats = longint'({32'd0, h}) + 1;
        bm = b & ~32'h7;
        sm = s & ~32'h7;
        exp_q.delete();
        for (longint g = 0; g < lines; g += LINES) begin
            col = 0;
            while (col < row_beats) begin
                nb = row_beats - col;
                if (nb > MAXB) nb = MAXB;
                e = '0;
                for (int j = 0; j < LINES; j++) begin
                    if (g + j < lines) begin
                        a   = bm + 32'(g + j) * sm + 32'(col * BYTES);
                        rem = a % 32'(BOUND);
                        bb  = (BOUND - longint'({32'd0, rem})) / BYTES;
                        if (bb < nb) nb = bb;
                        if (j == 0) e.a0 = a; else e.a1 = a;
                        e.m[j] = 1'b1;
                    end
                end
                e.len = 8'(nb - 1);
                exp_q.push_back(e);
                col += nb;
            end
        end
    endfunction

    task automatic check_desc(input string tag, input burst_t e);
        check({tag, "_addr0"}, addr[31:0], e.a0);
        check({tag, "_addr1"}, addr[63:32], e.a1);
        check({tag, "_mask"}, mask, e.m);
        check({tag, "_len"}, len, e.len);
        check({tag, "_valid"}, valid, 1'b1);
    endtask

    task automatic check_obs(input int idx, input logic [31:0] a0, input logic [31:0] a1,
                             input logic [1:0] m, input logic [7:0] l);
        burst_t o;
        if (idx >= obs_q.size()) begin
            check("obs_missing", idx, obs_q.size());
        end else begin
            o = obs_q[idx];
            check("obs_addr0", o.a0, a0);
            check("obs_addr1", o.a1, a1);
            check("obs_mask", o.m, m);
            check("obs_len", o.len, l);
        end
    endtask

    task automatic run_frame(input logic [31:0] b, input logic [31:0] s,
                             input logic [31:0] v, input logic [31:0] h,
                             input int stall_idx, input int abort_idx, input bit rand_stall);
        int     n, ns, d0;
        burst_t e, o;
        build(b, s, v, h);
        obs_q.delete();
        d0 = done_cnt;
        base = b; stride = s; vsize = v; hsize = h;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Config pins change while busy; they must not disturb the frame.
        base = $urandom; stride = $urandom; vsize = $urandom; hsize = $urandom;
        check("busy_after_start", busy, 1'b1);
        check("valid_in_calc", valid, 1'b0);
        for (int k = 0; k < exp_q.size(); k++) begin
            e = exp_q[k];
            n = 0;
            while (!valid && n < 8) begin
                @(negedge clk);
                n++;
            end
            check("issue_latency", n, 1);
            if (!valid) return;
            check_desc("burst", e);
            check("busy_in_frame", busy, 1'b1);
            o.a0 = addr[31:0]; o.a1 = addr[63:32]; o.m = mask; o.len = len;
            obs_q.push_back(o);
            if (k == abort_idx) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                check("abort_valid", valid, 1'b0);
                check("abort_busy", busy, 1'b0);
                check("abort_done", done, 1'b0);
                repeat (3) @(negedge clk);
                check("abort_no_done", done_cnt, d0);
                check("abort_stays_idle", busy, 1'b0);
                return;
            end
            ns = (k == stall_idx) ? 5 : (rand_stall ? int'($urandom_range(0, 2)) : 0);
            for (int c = 0; c < ns; c++) begin
                if (c == 2) start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                check_desc("stall", e);
            end
            ready = 1'b1;
            @(negedge clk);
            ready = 1'b0;
        end
        check("done_pulse", done, 1'b1);
        check("busy_in_done", busy, 1'b1);
        @(negedge clk);
        check("done_cleared", done, 1'b0);
        check("busy_cleared", busy, 1'b0);
        check("valid_idle", valid, 1'b0);
        check("done_count", done_cnt, d0 + 1);
        repeat (2) @(negedge clk);
        check("no_restart", busy, 1'b0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        base = '0; stride = '0; vsize = '0; hsize = '0;
        start = 1'b0; abort = 1'b0; ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", valid, 1'b0);
        check("rst_addr", addr, 64'd0);
        check("rst_mask", mask, 2'b00);
        check("rst_len", len, 8'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Two lanes, four lines, two bursts per row.
        run_frame(32'h1000, 32'h400, 32'd3, 32'd31, -1, -1, 1'b0);
        check("t1_count", obs_q.size(), 4);
        check_obs(0, 32'h1000, 32'h1400, 2'b11, 8'd15);
        check_obs(1, 32'h1080, 32'h1480, 2'b11, 8'd15);
        check_obs(2, 32'h1800, 32'h1C00, 2'b11, 8'd15);
        check_obs(3, 32'h1880, 32'h1C80, 2'b11, 8'd15);

        // Single line crossing 4 KB on lane 0.
        run_frame(32'h0FC0, 32'h1000, 32'd0, 32'd15, -1, -1, 1'b0);
        check("t2_count", obs_q.size(), 2);
        check_obs(0, 32'h0FC0, 32'h0, 2'b01, 8'd7);
        check_obs(1, 32'h1000, 32'h0, 2'b01, 8'd7);

        // Only lane 1 is near the boundary.
        run_frame(32'h0000, 32'h0FC0, 32'd1, 32'd15, -1, -1, 1'b0);
        check("t3_count", obs_q.size(), 2);
        check_obs(0, 32'h0000, 32'h0FC0, 2'b11, 8'd7);
        check_obs(1, 32'h0040, 32'h1000, 2'b11, 8'd7);

        // Short last group masks lane 1.
        run_frame(32'h0000, 32'h0100, 32'd2, 32'd15, -1, -1, 1'b0);
        check("t4_count", obs_q.size(), 2);
        check_obs(0, 32'h0000, 32'h0100, 2'b11, 8'd15);
        check_obs(1, 32'h0200, 32'h0000, 2'b01, 8'd15);

        // Back-pressure on the second burst, start pulsed meanwhile.
        run_frame(32'h1000, 32'h400, 32'd3, 32'd31, 1, -1, 1'b0);

        // Abort on the second burst, then a full clean frame.
        run_frame(32'h1000, 32'h400, 32'd3, 32'd31, -1, 1, 1'b0);
        run_frame(32'h1000, 32'h400, 32'd3, 32'd31, -1, -1, 1'b0);

        // Full-range sizes: hsize+1 and vsize+1 must not wrap to zero.
        base = 32'h0; stride = 32'h400; vsize = 32'hFFFF_FFFF; hsize = 32'hFFFF_FFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!valid && n < 8) begin @(negedge clk); n++; end
        check("max_latency", n, 1);
        check_desc("max", '{a0: 32'h0, a1: 32'h400, m: 2'b11, len: 8'd15});
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("max_abort_busy", busy, 1'b0);

        // Reset in the middle of a frame clears outputs immediately.
        base = 32'h1000; stride = 32'h400; vsize = 32'd3; hsize = 32'd31;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!valid && n < 8) begin @(negedge clk); n++; end
        check("rst_mid_valid_before", valid, 1'b1);
        n = done_cnt;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", valid, 1'b0);
        check("rst_mid_addr", addr, 64'd0);
        check("rst_mid_mask", mask, 2'b00);
        check("rst_mid_len", len, 8'd0);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_mid_no_done", done_cnt, n);

        // Random geometries, including unaligned inputs and address wrap.
        for (int i = 0; i < 16; i++) begin
            logic [31:0] rb, rs, rv, rh;
            rb = ($urandom & 32'h0000_3FFF) | ((i % 4 == 0) ? 32'hFFFF_C000 : 32'h0);
            rs = $urandom & 32'h0000_1FFF;
            rv = $urandom_range(0, 5);
            rh = $urandom_range(0, 40);
            run_frame(rb, rs, rv, rh, -1, -1, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
